// File: rtl/link_codec_pkg.sv
// -----------------------------------------------------------------------------
// link_codec_pkg
// Shared types and helpers for the receive side of the 8-to-3 encoded link.
//   CODE_W / ONEHOT_W : encoded index width and reconstructed one-hot width
//   entry_t           : one buffered link word {none, code}
//   code_to_onehot()  : reconstructs the one-hot value of an entry
//   ERR_*             : bit positions inside the sticky error status vector
// -----------------------------------------------------------------------------
package link_codec_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;
    localparam int ERR_PAR = 2;

    typedef struct packed {
        logic              none;
        logic [CODE_W-1:0] code;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // "none" means no encoder input was active, which reconstructs to all zeros.
    function automatic logic [ONEHOT_W-1:0] code_to_onehot(input entry_t e);
        logic [ONEHOT_W-1:0] onehot;
        onehot = '0;
        if (!e.none) begin
            onehot[e.code] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// -----------------------------------------------------------------------------
// link_fifo
// Generic DEPTH x WIDTH synchronous FIFO, head presented combinationally.
//   CLK    : clock, all updates on the rising edge
//   RST_N  : synchronous active-low reset (pointers and occupancy only)
//   push   : write wdata at the tail (ignored while full)
//   pop    : drop the head entry (ignored while empty)
//   wdata  : tail write data
//   rdata  : head entry, valid while !empty
//   full   : occupancy == DEPTH
//   empty  : occupancy == 0
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// A push and a pop while full only performs the pop.
// -----------------------------------------------------------------------------
module link_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push, do_pop;

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        do_push = push && !full;
        do_pop  = pop && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale contents are
    // unreachable because occupancy gates every read, and skipping the reset
    // keeps the array a plain register file.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/link_decoder.sv
// -----------------------------------------------------------------------------
// link_decoder
// Receive stage after the 8-to-3 priority encoder: buffers encoded link words,
// reconstructs the one-hot value at the head, keeps link diagnostics.
//   CLK, RST_N  : clock; synchronous active-low reset
//   put_code    : encoded index {a2,a1,a0}
//   put_none    : no encoder input active (decodes to 8'h00)
//   put_par     : even parity over {put_none, put_code} (LINK_PARITY_EN only)
//   EN_put      : enqueue strobe, accepted when RDY_put (and parity is good)
//   RDY_put     : FIFO not full
//   get_onehot  : head entry as one-hot, 8'h00 while empty
//   RDY_get     : FIFO not empty
//   EN_get      : dequeue strobe, performed when RDY_get
//   mv_err      : sticky {parity (LINK_PARITY_EN only), underflow, overflow}
//   mv_dropcnt  : saturating count of rejected puts
//   err_clr     : clears mv_err and mv_dropcnt; same-cycle events win
// Optional feature macro: LINK_PARITY_EN (adds put_par and mv_err[2]).
// -----------------------------------------------------------------------------
module link_decoder
    import link_codec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CODE_W-1:0]   put_code,
    input  logic                put_none,
    input  logic                EN_put,
`ifdef LINK_PARITY_EN
    input  logic                put_par,
    output logic [2:0]          mv_err,
`else
    output logic [1:0]          mv_err,
`endif
    output logic                RDY_put,
    output logic [ONEHOT_W-1:0] get_onehot,
    output logic                RDY_get,
    input  logic                EN_get,
    output logic [CNT_W-1:0]    mv_dropcnt,
    input  logic                err_clr
);

`ifdef LINK_PARITY_EN
    localparam int ERR_W = 3;
`else
    localparam int ERR_W = 2;
`endif

    entry_t               put_entry;
    entry_t               head;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic                 par_ok;
    logic                 put_acc, get_acc;
    logic                 ovf_evt, udf_evt, par_evt, drop_evt;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [CNT_W-1:0]     dropcnt_q, dropcnt_d;

    link_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (put_acc),
        .pop   (get_acc),
        .wdata (put_entry),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready flags come straight from registered occupancy, never from EN_*.
    assign RDY_put    = !fifo_full;
    assign RDY_get    = !fifo_empty;
    assign head       = entry_t'(fifo_rdata);
    assign get_onehot = RDY_get ? code_to_onehot(head) : '0;
    assign mv_err     = err_q;
    assign mv_dropcnt = dropcnt_q;

    always_comb begin
        put_entry      = '0;
        put_entry.none = put_none;
        put_entry.code = put_code;

`ifdef LINK_PARITY_EN
        par_ok = (put_par == ^put_entry);
`else
        par_ok = 1'b1;
`endif

        put_acc = EN_put && RDY_put && par_ok;
        get_acc = EN_get && RDY_get;

        ovf_evt = EN_put && !RDY_put;
        udf_evt = EN_get && !RDY_get;
        // A parity failure is judged independently of RDY_put.
        par_evt = EN_put && !par_ok;
        // Full and bad parity at once is still a single dropped word.
        drop_evt = ovf_evt || par_evt;

        // Clear first, then let same-cycle events re-set their flags.
        err_d = err_clr ? '0 : err_q;
        if (ovf_evt) err_d[ERR_OVF] = 1'b1;
        if (udf_evt) err_d[ERR_UDF] = 1'b1;
`ifdef LINK_PARITY_EN
        if (par_evt) err_d[ERR_PAR] = 1'b1;
`endif

        if (err_clr) begin
            dropcnt_d = drop_evt ? CNT_W'(1) : '0;
        end else if (drop_evt && (dropcnt_q != '1)) begin
            dropcnt_d = dropcnt_q + CNT_W'(1);
        end else begin
            dropcnt_d = dropcnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_q     <= '0;
            dropcnt_q <= '0;
        end else begin
            err_q     <= err_d;
            dropcnt_q <= dropcnt_d;
        end
    end

endmodule

// File: doc/link_decoder.md
Name: link_decoder

Overview:
- Receive-side stage directly downstream of the 8-to-3 priority encoder.
- Accepts 3-bit encoded codes (plus a "no input active" flag) from the transmission link and buffers them in a small FIFO.
- Reconstructs the 8-bit one-hot value and presents it through a ready/enable get method.
- Keeps sticky error status and a saturating drop counter for link diagnostics.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the drop counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
- put_code  input  3  encoded index {a2,a1,a0} from the link.
- put_none  input  1  1 = no encoder input was active (code ignored; decodes to 8'h00).
- EN_put  input  1  enqueue strobe.
- RDY_put  output  1  1 = FIFO not full.
- get_onehot  output  8  head entry decoded to one-hot.
- RDY_get  output  1  1 = FIFO not empty.
- EN_get  input  1  dequeue strobe.
- mv_err  output  2  sticky status: bit0 = overflow (EN_put while full), bit1 = underflow (EN_get while empty).
- mv_dropcnt  output  CNT_W  saturating count of rejected puts.
- err_clr  input  1  clears mv_err and mv_dropcnt.

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - FIFO pointers and occupancy cleared; RDY_put=1, RDY_get=0, get_onehot=8'h00.
  - mv_err=0, mv_dropcnt=0.
  - Reset has priority over every other input, so an in-flight put or get in that cycle is discarded.
- Storage and decode:
  - Each entry stores 4 bits {none, code}.
  - Decode: none=1 -> 8'h00; otherwise 8'h01 << code.
  - Decode is combinational from the head entry. get_onehot=8'h00 whenever the FIFO is empty.
- Latency:
  - A word accepted at edge N is visible on get_onehot, with RDY_get=1, in the cycle after edge N when the FIFO was empty.
  - No bypass path.
- Handshake:
  - Put is accepted iff EN_put && RDY_put.
  - Get is performed iff EN_get && RDY_get.
  - RDY_put and RDY_get are registered-state functions only: no combinational path from EN_* to RDY_*.
- Occupancy:
  - Counter width clog2(DEPTH)+1.
  - RDY_put = (occ != DEPTH); RDY_get = (occ != 0).
- Simultaneous put+get:
  - When 0 < occ < DEPTH, both are performed and occ is unchanged.
  - When full, only the get is performed; the put is rejected (overflow).
  - When empty, only the put is performed; the get is rejected (underflow), and the new word appears next cycle.
- Rejected put:
  - mv_err[0] is set and mv_dropcnt increments, saturating at all-ones.
  - FIFO contents are unchanged.
- Rejected get: mv_err[1] is set; no state change otherwise.
- err_clr:
  - Clears both mv_err and mv_dropcnt.
  - If an error event occurs in the same cycle, the event wins: the flag is set and the count becomes 1.
- Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: LINK_PARITY_EN.
- Defined:
  - Adds input put_par (1 bit, even parity over {put_none, put_code}) and output mv_err bit2 (parity error, sticky).
  - A put with a parity mismatch is not enqueued, sets mv_err[2] and increments mv_dropcnt.
  - This happens regardless of RDY_put; when a word is both full-rejected and has a parity error, mv_dropcnt increments once.
  - mv_err width becomes 3.
- Undefined: no put_par port; mv_err is 2 bits; all puts are parity-free.

Decomposition:
- Package link_codec_pkg:
  - CODE_W=3, ONEHOT_W=8.
  - Entry struct {none, code}.
  - Function code_to_onehot.
  - Error-bit index constants ERR_OVF=0, ERR_UDF=1, ERR_PAR=2.
- Sub-module link_fifo:
  - Generic DEPTH x width synchronous FIFO with full/empty and occupancy.
  - Instantiated once.
  - Decode and error logic stay in link_decoder.

Test Plan:
- Reset, then put code=3'd5, none=0; next cycle -> RDY_get=1, get_onehot=8'h20; EN_get -> RDY_get=0, get_onehot=8'h00.
- Put none=1, code=3'd7 -> get_onehot=8'h00 with RDY_get=1, so it is distinguishable from empty.
- Fill with 4 puts of codes 0,1,2,3 -> RDY_put=0. A 5th put -> mv_err=2'b01, mv_dropcnt=1. Drain -> 8'h01, 8'h02, 8'h04, 8'h08 in order.
- Full FIFO with simultaneous EN_put+EN_get -> occ goes 4 to 3, put dropped, mv_dropcnt increments. At occ=2, simultaneous put+get -> occ stays 2, FIFO order preserved across pointer wrap.
- EN_get on empty -> mv_err[1]=1. Then err_clr -> mv_err=0. 300 rejected puts -> mv_dropcnt saturates at 8'hFF. RST_N=0 mid-stream -> all outputs return to reset values on the next edge.
- LINK_PARITY_EN: put {none=0, code=3'b011} with put_par=1 (wrong) -> not enqueued, mv_err[2]=1, mv_dropcnt=1. With put_par=0 -> enqueued, get_onehot=8'h08.
